// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the CPU (port 0) and the
// debug/loader port (port 1). Define DMEM_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties).
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              req0,
    input  logic              req1,
    input  logic              wrEn0,
    input  logic              wrEn1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] dataIn0,
    input  logic [DATA_W-1:0] dataIn1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              valid0,
    output logic              valid1,
    output logic [DATA_W-1:0] dataOut0,
    output logic [DATA_W-1:0] dataOut1,
    output logic              memWrEn,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memDataIn,
    input  logic [DATA_W-1:0] memDataOut,
    output logic [1:0]        dbg_state
);

    // Handshake: a requester holds req with stable wrEn/addr/dataIn until gnt; gnt is a one-cycle
    // accept pulse, valid a one-cycle completion pulse (read data in dataOut, or write ack).

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              arb_go;
    logic              win;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              cur_port;
    logic              cur_wr;
    logic              cur_port_nxt;
    logic              cur_wr_nxt;

    logic              gnt0_nxt;
    logic              gnt1_nxt;
    logic              valid0_nxt;
    logic              valid1_nxt;
    logic [DATA_W-1:0] dout0_nxt;
    logic [DATA_W-1:0] dout1_nxt;
    logic              mem_wr_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_din_nxt;

    // Arbitration points are IDLE and RESP; a new access can start on the RESP edge.
    assign arb_go = ((state == IDLE) || (state == RESP)) && (req0 || req1);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign win = req1 & ~req0;
`else
    logic last_gnt;

    assign win = (req0 && req1) ? ~last_gnt : req1;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            last_gnt <= 1'b1;
        end else if (arb_go) begin
            last_gnt <= win;
        end
    end
`endif

    assign sel_wr   = win ? wrEn1   : wrEn0;
    assign sel_addr = win ? addr1   : addr0;
    assign sel_data = win ? dataIn1 : dataIn0;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arb_go) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = arb_go ? ACCESS : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt0_nxt     = 1'b0;
        gnt1_nxt     = 1'b0;
        valid0_nxt   = 1'b0;
        valid1_nxt   = 1'b0;
        dout0_nxt    = dataOut0;
        dout1_nxt    = dataOut1;
        mem_wr_nxt   = 1'b0;
        mem_addr_nxt = memAddr;
        mem_din_nxt  = memDataIn;
        cur_port_nxt = cur_port;
        cur_wr_nxt   = cur_wr;

        // Memory produced the read data at the ACCESS->RESP edge; retire it now.
        if (state == RESP) begin
            if (cur_port) begin
                valid1_nxt = 1'b1;
                if (!cur_wr) dout1_nxt = memDataOut;
            end else begin
                valid0_nxt = 1'b1;
                if (!cur_wr) dout0_nxt = memDataOut;
            end
        end

        if (arb_go) begin
            gnt0_nxt     = ~win;
            gnt1_nxt     = win;
            cur_port_nxt = win;
            cur_wr_nxt   = sel_wr;
            mem_wr_nxt   = sel_wr;
            mem_addr_nxt = sel_addr;
            mem_din_nxt  = sel_data;
        end
    end

    // memWrEn sits in the async-reset domain so a reset mid-ACCESS blocks the pending write.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            valid0    <= 1'b0;
            valid1    <= 1'b0;
            dataOut0  <= '0;
            dataOut1  <= '0;
            memWrEn   <= 1'b0;
            memAddr   <= '0;
            memDataIn <= '0;
            cur_port  <= 1'b0;
            cur_wr    <= 1'b0;
        end else begin
            gnt0      <= gnt0_nxt;
            gnt1      <= gnt1_nxt;
            valid0    <= valid0_nxt;
            valid1    <= valid1_nxt;
            dataOut0  <= dout0_nxt;
            dataOut1  <= dout1_nxt;
            memWrEn   <= mem_wr_nxt;
            memAddr   <= mem_addr_nxt;
            memDataIn <= mem_din_nxt;
            cur_port  <= cur_port_nxt;
            cur_wr    <= cur_wr_nxt;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: single-port memory model, transaction-level reference model with
// per-cycle comparison, and directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 300;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } txn_t;

    typedef struct packed {
        logic          v;
        logic          p;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } grant_t;

    logic          clk    = 1'b0;
    logic          resetN = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, wrEn0 = 1'b0, wrEn1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] dataIn0 = '0, dataIn1 = '0;
    logic          gnt0, gnt1, valid0, valid1, memWrEn;
    logic [DW-1:0] dataOut0, dataOut1, memDataIn, memDataOut;
    logic [AW-1:0] memAddr;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    txn_t q0[$];
    txn_t q1[$];

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .resetN(resetN),
        .req0(req0), .req1(req1), .wrEn0(wrEn0), .wrEn1(wrEn1),
        .addr0(addr0), .addr1(addr1), .dataIn0(dataIn0), .dataIn1(dataIn1),
        .gnt0(gnt0), .gnt1(gnt1), .valid0(valid0), .valid1(valid1),
        .dataOut0(dataOut0), .dataOut1(dataOut1),
        .memWrEn(memWrEn), .memAddr(memAddr), .memDataIn(memDataIn), .memDataOut(memDataOut),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- single-port memory ----------------
    logic [DW-1:0] mem [0:63];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[1] = 32'h1111_0004;
        mem[3] = 32'h3333_000C;
    end

    always @(posedge clk) begin
        if (memWrEn) mem[memAddr[7:2]] <= memDataIn;
        memDataOut <= mem[memAddr[7:2]];
    end

    // ---------------- reference model ----------------
    logic [DW-1:0] ref_mem [0:63];
    grant_t        g1, g2, gn;
    int            mcyc, next_arb;
    logic          last_w;
    logic          exp_gnt0, exp_gnt1, exp_valid0, exp_valid1, exp_rd;
    logic          exp_acc, exp_wr_en;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din;
    logic [DW-1:0] exp_q0[$];
    logic [DW-1:0] exp_q1[$];

    task automatic reset_model();
        g1 = '0; g2 = '0; mcyc = 0; next_arb = 0; last_w = 1'b1;
        exp_gnt0 = 0; exp_gnt1 = 0; exp_valid0 = 0; exp_valid1 = 0; exp_rd = 0;
        exp_acc = 0; exp_wr_en = 0; exp_addr = '0; exp_din = '0;
        exp_q0.delete();
        exp_q1.delete();
    endtask

    initial begin : model
        logic w;
        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        ref_mem[1] = 32'h1111_0004;
        ref_mem[3] = 32'h3333_000C;
        reset_model();
        forever begin
            @(posedge clk or negedge resetN);
            if (!resetN) begin
                reset_model();
            end else begin
                mcyc++;
                // Completion of the access granted two edges ago.
                exp_valid0 = g2.v && !g2.p;
                exp_valid1 = g2.v && g2.p;
                exp_rd     = g2.v && !g2.wr;
                // Memory executes the access granted one edge ago.
                if (g1.v) begin
                    if (g1.wr) ref_mem[g1.addr[7:2]] = g1.data;
                    else if (g1.p) exp_q1.push_back(ref_mem[g1.addr[7:2]]);
                    else exp_q0.push_back(ref_mem[g1.addr[7:2]]);
                end
                gn = '0;
                if (mcyc >= next_arb && (req0 || req1)) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                    w = (req0 && req1) ? 1'b0 : req1;
`else
                    w = (req0 && req1) ? ~last_w : req1;
`endif
                    gn.v    = 1'b1;
                    gn.p    = w;
                    gn.wr   = w ? wrEn1 : wrEn0;
                    gn.addr = w ? addr1 : addr0;
                    gn.data = w ? dataIn1 : dataIn0;
                    last_w   = w;
                    next_arb = mcyc + 2;
                end
                exp_gnt0  = gn.v && !gn.p;
                exp_gnt1  = gn.v && gn.p;
                exp_acc   = gn.v;
                exp_wr_en = gn.v && gn.wr;
                exp_addr  = gn.addr;
                exp_din   = gn.data;
                g2 = g1;
                g1 = gn;
            end
        end
    end

    // ---------------- requester drivers ----------------
    initial begin : drv0
        forever begin
            @(negedge clk);
            if (resetN && gnt0 && q0.size() > 0) q0.delete(0);
            if (resetN && q0.size() > 0) begin
                req0 = 1'b1; wrEn0 = q0[0].wr; addr0 = q0[0].addr; dataIn0 = q0[0].data;
            end else begin
                req0 = 1'b0;
            end
        end
    end

    initial begin : drv1
        forever begin
            @(negedge clk);
            if (resetN && gnt1 && q1.size() > 0) q1.delete(0);
            if (resetN && q1.size() > 0) begin
                req1 = 1'b1; wrEn1 = q1[0].wr; addr1 = q1[0].addr; dataIn1 = q1[0].data;
            end else begin
                req1 = 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    logic [DW-1:0] last_dout0 = '0, last_dout1 = '0;
    int            gnt_hist[$];
    int            gnt_cyc[2];
    int            valid_cyc[2];
    int            valid_cnt[2];
    logic [AW-1:0] last_wr_addr = '0;

    initial begin : compare
        forever begin
            @(negedge clk);
            if (!resetN) begin
                last_dout0 = '0;
                last_dout1 = '0;
                chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
                chk("rst_valid", {30'd0, valid1, valid0}, 32'd0);
                chk("rst_dout0", dataOut0, 32'd0);
                chk("rst_dout1", dataOut1, 32'd0);
                chk("rst_mem", {31'd0, memWrEn} | memAddr | memDataIn, 32'd0);
            end else begin
                if (exp_valid0 && exp_rd) begin
                    if (exp_q0.size() == 0) chk("exp_q0_empty", 32'd0, 32'd1);
                    else last_dout0 = exp_q0.pop_front();
                end
                if (exp_valid1 && exp_rd) begin
                    if (exp_q1.size() == 0) chk("exp_q1_empty", 32'd0, 32'd1);
                    else last_dout1 = exp_q1.pop_front();
                end
                chk("gnt0", gnt0, exp_gnt0);
                chk("gnt1", gnt1, exp_gnt1);
                chk("valid0", valid0, exp_valid0);
                chk("valid1", valid1, exp_valid1);
                chk("dataOut0", dataOut0, last_dout0);
                chk("dataOut1", dataOut1, last_dout1);
                chk("memWrEn", memWrEn, exp_wr_en);
                if (exp_acc) chk("memAddr", memAddr, exp_addr);
                if (exp_wr_en) chk("memDataIn", memDataIn, exp_din);
                if (gnt0) begin gnt_hist.push_back(0); gnt_cyc[0] = cyc; end
                if (gnt1) begin gnt_hist.push_back(1); gnt_cyc[1] = cyc; end
                if (valid0) begin valid_cnt[0]++; valid_cyc[0] = cyc; end
                if (valid1) begin valid_cnt[1]++; valid_cyc[1] = cyc; end
                if (memWrEn) last_wr_addr = memAddr;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push0(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.wr = wr; t.addr = a; t.data = d;
        q0.push_back(t);
    endtask

    task automatic push1(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        txn_t t;
        t.wr = wr; t.addr = a; t.data = d;
        q1.push_back(t);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || g1.v || g2.v || req0 || req1) && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", n < TIMEOUT, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 resetN = 1'b0;
        repeat (2) @(negedge clk);
        #1 resetN = 1'b1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog cyc=%0d act=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin : main
        int n;
        int rr_exp[8];
        repeat (3) @(negedge clk);
        #1 resetN = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", dbg_state, 32'd0);

        // Single write then read-back on port 0.
        push0(1'b1, 32'd8, 32'hA5A5_0001);
        wait_idle();
        chk("wr_latency", valid_cyc[0] - gnt_cyc[0], 32'd2);
        chk("wr_mem_addr", last_wr_addr, 32'd8);
        push0(1'b0, 32'd8, 32'd0);
        wait_idle();
        chk("rd_back", dataOut0, 32'hA5A5_0001);
        chk("rd_latency", valid_cyc[0] - gnt_cyc[0], 32'd2);

        // Tie straight after reset: port 0 first, port 1 at the RESP edge.
        pulse_reset();
        @(negedge clk);
        gnt_hist.delete();
        push0(1'b0, 32'd4, 32'd0);
        push1(1'b0, 32'd12, 32'd0);
        wait_idle();
        chk("tie_first", gnt_hist.size() > 0 ? gnt_hist[0] : 9, 32'd0);
        chk("tie_second", gnt_hist.size() > 1 ? gnt_hist[1] : 9, 32'd1);
        chk("tie_valid_gap", valid_cyc[1] - valid_cyc[0], 32'd2);
        chk("tie_dout0", dataOut0, 32'h1111_0004);
        chk("tie_dout1", dataOut1, 32'h3333_000C);

        // Both ports held busy for many grants.
        gnt_hist.delete();
        for (int i = 0; i < 8; i++) push0(1'b0, AW'(i * 4), 32'd0);
        for (int i = 0; i < 8; i++) push1(1'b0, (i == 7) ? 32'd12 : AW'(i * 4), 32'd0);
        wait_idle();
        for (int i = 0; i < 8; i++) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            rr_exp[i] = 0;
`else
            rr_exp[i] = i % 2;
`endif
            chk($sformatf("fair_gnt%0d", i), gnt_hist.size() > i ? gnt_hist[i] : 9, rr_exp[i]);
        end

        // Write isolation: port 1 writes, port 0 reads it back.
        push1(1'b1, 32'd16, 32'h0000_1234);
        wait_idle();
        push0(1'b0, 32'd16, 32'd0);
        wait_idle();
        chk("iso_dout0", dataOut0, 32'h0000_1234);
        chk("iso_dout1", dataOut1, 32'h3333_000C);

        // Reset during the ACCESS cycle of a write to addr 20.
        push1(1'b0, 32'd16, 32'd0);
        wait_idle();
        chk("pre_rst_dout1", dataOut1, 32'h0000_1234);
        push0(1'b1, 32'd20, 32'hDEAD_BEEF);
        n = 0;
        while (!gnt0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_gnt_seen", gnt0, 32'd1);
        chk("abort_in_access", memWrEn, 32'd1);
        #2 resetN = 1'b0;
        #1;
        chk("async_rst_memWrEn", memWrEn, 32'd0);
        chk("async_rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("async_rst_addr", memAddr, 32'd0);
        chk("async_rst_state", dbg_state, 32'd0);
        valid_cnt[0] = 0;
        repeat (2) @(negedge clk);
        #1 resetN = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_no_valid", valid_cnt[0], 32'd0);
        chk("abort_mem_word", mem[5], 32'd0);
        push1(1'b0, 32'd16, 32'd0);
        wait_idle();
        chk("post_rst_rd16", dataOut1, 32'h0000_1234);
        push1(1'b0, 32'd20, 32'd0);
        wait_idle();
        chk("post_rst_rd20", dataOut1, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
